// File: rtl/fifo_serializer_if.sv
// fifo_serializer_if: upstream FIFO read port, shift enable and serial output bundle.
// slave is the serializer side, master is the side that owns the FIFO and consumes the stream.
interface fifo_serializer_if #(
    parameter int unsigned bits = 8
);
    logic [bits-1:0] Din;
    logic            pndng;
    logic            en;
    logic            pop;
    logic            sout;
    logic            sout_valid;
    logic            frame_start;
    logic            busy;

    modport slave (
        input  Din, pndng, en,
        output pop, sout, sout_valid, frame_start, busy
    );

    modport master (
        output Din, pndng, en,
        input  pop, sout, sout_valid, frame_start, busy
    );
endinterface

// File: rtl/fifo_serializer.sv
// fifo_serializer: pops words from an upstream FIFO and shifts them out MSB first.
// Define FIFO_SERIALIZER_PARITY_EN to append an even-parity bit after each word's LSB.
module fifo_serializer #(
    parameter int unsigned bits = 8
) (
    input logic              clk,
    input logic              rst,
    fifo_serializer_if.slave bus
);
    localparam int unsigned     CntW    = (bits > 1) ? $clog2(bits) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(bits - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StShift  = 2'd1;
`ifdef FIFO_SERIALIZER_PARITY_EN
    localparam logic [1:0] StParity = 2'd2;
`endif

    logic [1:0]      state_q, state_d;
    logic [bits-1:0] sr_q, sr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sout_q, sout_d;
    logic            valid_q, valid_d;
    logic            start_q, start_d;
    logic            frame_end;
    logic            pop;

    // Final cycle of a frame and the FIFO read strobe; a new word may start right behind it.
    always_comb begin
`ifdef FIFO_SERIALIZER_PARITY_EN
        frame_end = (state_q == StParity);
`else
        frame_end = (state_q == StShift) && (cnt_q == '0);
`endif
        pop = rst && bus.en && bus.pndng && ((state_q == StIdle) || frame_end);
    end

    // Next-state: capture on pop, otherwise walk the counter down; en=0 freezes everything.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        sout_d  = sout_q;
        valid_d = valid_q;
        start_d = start_q;
        if (bus.en) begin
            if (pop) begin
                state_d = StShift;
                sr_d    = bus.Din;
                cnt_d   = CntLast;
                sout_d  = bus.Din[bits-1];
                valid_d = 1'b1;
                start_d = 1'b1;
            end else begin
                case (state_q)
                    StShift: begin
                        if (cnt_q != '0) begin
                            // cnt tracks the index of the bit currently on sout
                            cnt_d   = cnt_q - 1'b1;
                            sout_d  = sr_q[cnt_d];
                            valid_d = 1'b1;
                            start_d = 1'b0;
                        end else begin
`ifdef FIFO_SERIALIZER_PARITY_EN
                            state_d = StParity;
                            sout_d  = ^sr_q;
                            valid_d = 1'b1;
                            start_d = 1'b0;
`else
                            state_d = StIdle;
                            sout_d  = 1'b0;
                            valid_d = 1'b0;
                            start_d = 1'b0;
`endif
                        end
                    end
                    default: begin
                        // Idle, or frame end with nothing pending upstream
                        state_d = StIdle;
                        sout_d  = 1'b0;
                        valid_d = 1'b0;
                        start_d = 1'b0;
                    end
                endcase
            end
        end
    end

    // State registers with synchronous active-low reset; a partial word is simply dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            start_q <= start_d;
        end
    end

    // Qualifiers are masked by en so a stalled bit is not counted until shifting resumes.
    assign bus.pop         = pop;
    assign bus.sout        = sout_q;
    assign bus.sout_valid  = valid_q && bus.en;
    assign bus.frame_start = start_q && bus.en;
    assign bus.busy        = (state_q != StIdle);
endmodule

// File: doc/fifo_serializer.md
FIFO_SERIALIZER -- requirements
Module: fifo_serializer

Interface
REQ-001 SHALL have parameter bits, default 8, width of one FIFO word.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port Din  input  bits  word from upstream FIFO Dout; valid whenever pndng=1.
REQ-005 SHALL have port pndng  input  1  upstream FIFO holds at least one unread word.
REQ-006 SHALL have port en  input  1  shift enable; 0 stalls the block.
REQ-007 SHALL have port pop  output  1  one-cycle read strobe to upstream FIFO.
REQ-008 SHALL have port sout  output  1  serial data, MSB first, registered.
REQ-009 SHALL have port sout_valid  output  1  sout carries a frame bit this cycle.
REQ-010 SHALL have port frame_start  output  1  high on the first bit of every frame.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress (state not IDLE).

Function
REQ-012 SHALL implement states IDLE, SHIFT and, with PARITY_EN, PARITY.
REQ-013 SHALL drive pop combinationally: pop=1 iff en=1, pndng=1 and the block is in IDLE or in the final cycle of a frame.
REQ-014 SHALL, on each edge with pop=1, capture Din into a bits-wide shift register, set the bit counter to bits-1 and enter SHIFT.
REQ-015 SHALL emit the first bit of a captured word on sout, with sout_valid=1 and frame_start=1, in the cycle after pop: one cycle of latency.
REQ-016 SHALL, in SHIFT with en=1, present the next bit each cycle (MSB to LSB) and decrement the counter; the counter is $clog2(bits) wide and never wraps below 0.
REQ-017 SHALL, after the LSB cycle, go to PARITY if compiled in; otherwise go to SHIFT on a back-to-back pop, or else to IDLE.
REQ-018 SHALL, back-to-back, start the next frame in the cycle after the final bit with no gap, and assert pop exactly once per word.
REQ-019 SHALL, when en=0, hold state, counter and sout; force sout_valid=0, frame_start=0 and pop=0; keep busy unchanged.
REQ-020 SHALL never assert pop when pndng=0; if pndng=0 at frame end, SHALL go to IDLE with sout_valid=0 and sout=0.
REQ-021 SHALL keep frame_start high for exactly one valid cycle per frame.

Reset
REQ-022 SHALL, on a rising clk edge with rst=0, enter IDLE and clear the shift register and counter; sout, sout_valid, frame_start and busy SHALL be 0.
REQ-023 SHALL hold pop=0 while rst=0.
REQ-024 SHALL, on reset mid-frame, discard the partial word without re-reading it and resume from IDLE after rst returns to 1.

Configuration
REQ-025 SHALL support the macro FIFO_SERIALIZER_PARITY_EN.
REQ-026 SHALL, when the macro is defined, append one PARITY cycle after the LSB:
- sout = XOR of all captured bits (even parity), sout_valid=1.
- The PARITY cycle is the frame's final cycle for REQ-013/REQ-018.
REQ-027 SHALL, when the macro is undefined, omit the PARITY state entirely; a frame is exactly bits valid cycles.

Verification
REQ-028 SHALL verify reset: rst=0 for 2 cycles with pndng=1 -> pop=0 throughout; all outputs 0 at the next edge.
REQ-029 SHALL verify a single word: bits=8, Din=8'hA5, pndng=1 for one word, en=1:
- pop high for 1 cycle at t.
- sout=1,0,1,0,0,1,0,1 in cycles t+1..t+8.
- frame_start only at t+1; busy falls after t+8 (no parity).
REQ-030 SHALL verify back-to-back words: 8'hFF then 8'h00 -> pop at t and t+8; 16 contiguous sout_valid cycles; frame_start at t+1 and t+9.
REQ-031 SHALL verify a stall: en=0 for 2 cycles after the 3rd bit of 8'hA5 -> sout holds, sout_valid=0, pop=0; the remaining 5 bits follow unchanged.
REQ-032 SHALL verify parity: FIFO_SERIALIZER_PARITY_EN defined, Din=8'h07 -> 9th valid cycle sout=1; next pop no earlier than that cycle.
REQ-033 SHALL verify reset mid-frame: rst=0 during the 5th bit -> next edge all outputs 0 and IDLE; with pndng=1 after release, the next word starts with pop and frame_start after one-cycle latency.
